vga_scanout: RTL

// - Pixel-side transmitter for the VGA path.
// - Generates raster timing: hsync, vsync, data-enable and pixel coordinates.
// - Pulls pixels from an upstream source, such as a framebuffer reader or line FIFO,

---
 rtl/vga_scanout.sv | 109 ++++++++++
 1 files changed

// File: rtl/vga_scanout.sv
// VGA raster generator and pixel transmitter: pulls pixels over valid/ready during
// active video and drives registered, mutually aligned sync/DE/RGB outputs.
module vga_scanout #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int PIX_W    = 12
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic [PIX_W-1:0] pix_data,
    input  logic             pix_valid,
    output logic             pix_ready,
    input  logic             underflow_clr,
    output logic             vga_hs,
    output logic             vga_vs,
    output logic             vga_de,
    output logic [PIX_W-1:0] vga_rgb,
    output logic [10:0]      hcount,
    output logic [9:0]       vcount,
    output logic             frame_start,
    output logic             underflow
);

    // Handshake: pix_ready depends only on rstn, en and the raster position,
    // never on pix_valid; a pixel moves when pix_ready & pix_valid at an edge.

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_timing
        $error("vga_scanout: active/porch/sync parameters must be >= 1");
    end
    if (H_TOTAL - 1 > 2047 || V_TOTAL - 1 > 1023) begin : g_bad_width
        $error("vga_scanout: H_TOTAL/V_TOTAL exceed hcount/vcount width");
    end

    localparam logic [10:0] H_ACT_C  = 11'(H_ACTIVE);
    localparam logic [10:0] H_LAST_C = 11'(H_TOTAL - 1);
    localparam logic [10:0] HS_BEG_C = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END_C = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  V_ACT_C  = 10'(V_ACTIVE);
    localparam logic [9:0]  V_LAST_C = 10'(V_TOTAL - 1);
    localparam logic [9:0]  VS_BEG_C = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END_C = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [10:0] h;
    logic [9:0]  v;
    logic        act;
    logic        hs_on;
    logic        vs_on;
    logic        transfer;

    always_comb begin
        act      = (h < H_ACT_C) && (v < V_ACT_C);
        hs_on    = (h >= HS_BEG_C) && (h < HS_END_C);
        vs_on    = (v >= VS_BEG_C) && (v < VS_END_C);
        pix_ready = en & rstn & act;
        transfer = pix_ready & pix_valid;
    end

    always_ff @(posedge clk) begin
        if (!rstn || !en) begin
            // Both reset and disable abort the frame; only reset drops the sticky flag.
            h           <= '0;
            v           <= '0;
            vga_de      <= 1'b0;
            vga_hs      <= ~HS_POL;
            vga_vs      <= ~VS_POL;
            vga_rgb     <= '0;
            hcount      <= '0;
            vcount      <= '0;
            frame_start <= 1'b0;
            if (!rstn) begin
                underflow <= 1'b0;
            end
        end else begin
            if (h == H_LAST_C) begin
                h <= '0;
                v <= (v == V_LAST_C) ? 10'd0 : v + 10'd1;
            end else begin
                h <= h + 11'd1;
            end
            vga_de      <= act;
            vga_hs      <= hs_on ? HS_POL : ~HS_POL;
            vga_vs      <= vs_on ? VS_POL : ~VS_POL;
            vga_rgb     <= transfer ? pix_data : '0;
            hcount      <= h;
            vcount      <= v;
            frame_start <= (h == 11'd0) && (v == 10'd0);
            // A fresh underflow beats a simultaneous clear.
            if (act && !pix_valid) begin
                underflow <= 1'b1;
            end else if (underflow_clr) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule
